// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window generator and the X/Y filter stages.
// Pixels are RGB444 packed {R[11:8],G[7:4],B[3:0]}; a window is nine 12-bit lanes.
// Lane idx occupies bits [idx*PIX_W +: PIX_W], so TAP_CENTER sits in the MSBs.
package sobel_pkg;

  localparam int PIX_W = 12;
  localparam int WIN_W = 9 * PIX_W;

  localparam int TAP_CENTER = 8;
  localparam int TAP_LEFT   = 7;
  localparam int TAP_RIGHT  = 6;
  localparam int TAP_UP     = 5;
  localparam int TAP_DOWN   = 4;
  localparam int TAP_UL     = 3;
  localparam int TAP_UR     = 2;
  localparam int TAP_DL     = 1;
  localparam int TAP_DR     = 0;

  function automatic logic [PIX_W-1:0] tap(input logic [WIN_W-1:0] win, input int idx);
    return win[idx*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-row pixel store for the 3x3 window generator.
// Ports: clk; en (write strobe); addr (column); wr_data; rd_data (combinational read).
// Read is asynchronous, so a read and write at the same address in one cycle
// returns the old contents (read-before-write). Contents are never cleared.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 12,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel X/Y filters; 1 clk accept->window.
// Ports: clk, reset (async, active-high), pix_in/pix_valid/sof in; window_out, window_valid,
// frame_err out. No backpressure. Optional macro SOBEL_WINDOW_COORD_EN adds win_x/win_y.
module sobel_window_3x3_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [WIN_W-1:0] window_out,
  output logic             window_valid,
`ifdef SOBEL_WINDOW_COORD_EN
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
`endif
  output logic             frame_err
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;
  logic [CW-1:0] nxt_col;
  logic [RW-1:0] nxt_row;
  logic          sof_acc;

  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  // Shift array, index 0 = left column, 2 = right column.
  logic [PIX_W-1:0] up_q  [3];
  logic [PIX_W-1:0] mid_q [3];
  logic [PIX_W-1:0] dn_q  [3];

  // A qualified sof forces this pixel to (0,0) whatever the counters say.
  assign sof_acc = pix_valid && sof;

  always_comb begin
    eff_col = sof_acc ? '0 : col;
    eff_row = sof_acc ? '0 : row;
    nxt_col = eff_col + COL_ONE;
    nxt_row = eff_row;
    if (eff_col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = (eff_row == ROW_LAST) ? '0 : eff_row + ROW_ONE;
    end
  end

  // lb1 holds row r-1, lb0 holds row r-2; lb0 takes lb1's old value at the same column.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) lb1 (
    .clk     (clk),
    .en      (pix_valid),
    .addr    (eff_col),
    .wr_data (pix_in),
    .rd_data (lb1_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) lb0 (
    .clk     (clk),
    .en      (pix_valid),
    .addr    (eff_col),
    .wr_data (lb1_rd),
    .rd_data (lb0_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      frame_err    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        up_q[i]  <= '0;
        mid_q[i] <= '0;
        dn_q[i]  <= '0;
      end
    end else begin
      window_valid <= pix_valid && (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);
      frame_err    <= sof_acc && ((row != '0) || (col != '0));
      if (pix_valid) begin
        col <= nxt_col;
        row <= nxt_row;
        for (int i = 0; i < 2; i++) begin
          up_q[i]  <= up_q[i+1];
          mid_q[i] <= mid_q[i+1];
          dn_q[i]  <= dn_q[i+1];
        end
        up_q[2]  <= lb0_rd;
        mid_q[2] <= lb1_rd;
        dn_q[2]  <= pix_in;
      end
    end
  end

`ifdef SOBEL_WINDOW_COORD_EN
  // Centre coordinate of the window being produced, latched with window_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_x <= '0;
      win_y <= '0;
    end else if (pix_valid && (eff_row >= ROW_TWO) && (eff_col >= COL_TWO)) begin
      win_x <= eff_col - COL_ONE;
      win_y <= eff_row - ROW_ONE;
    end
  end
`endif

  // Packing is straight from the shift array, so the window holds until the next accept.
  always_comb begin
    window_out = '0;
    window_out[TAP_CENTER*PIX_W +: PIX_W] = mid_q[1];
    window_out[TAP_LEFT*PIX_W   +: PIX_W] = mid_q[0];
    window_out[TAP_RIGHT*PIX_W  +: PIX_W] = mid_q[2];
    window_out[TAP_UP*PIX_W     +: PIX_W] = up_q[1];
    window_out[TAP_DOWN*PIX_W   +: PIX_W] = dn_q[1];
    window_out[TAP_UL*PIX_W     +: PIX_W] = up_q[0];
    window_out[TAP_UR*PIX_W     +: PIX_W] = up_q[2];
    window_out[TAP_DL*PIX_W     +: PIX_W] = dn_q[0];
    window_out[TAP_DR*PIX_W     +: PIX_W] = dn_q[2];
  end

endmodule

// File: tb/tb_sobel_window_3x3_gen.sv
// Directed bench for sobel_window_3x3_gen at 8x6; pixel(r,c) = {r[3:0], c[3:0], 4'h5}.
// Covers reset, continuous and gapped frames, early sof, and reset mid-frame.
module tb_sobel_window_3x3_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic         clk;
  logic         reset;
  logic [11:0]  pix_in;
  logic         pix_valid;
  logic         sof;
  logic [107:0] window_out;
  logic         window_valid;
  logic         frame_err;
`ifdef SOBEL_WINDOW_COORD_EN
  logic [2:0]   win_x;
  logic [2:0]   win_y;
`endif

  int checks;
  int failures;
  int nwin;

  sobel_window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .sof          (sof),
    .window_out   (window_out),
    .window_valid (window_valid),
`ifdef SOBEL_WINDOW_COORD_EN
    .win_x        (win_x),
    .win_y        (win_y),
`endif
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pix(input int r, input int c);
    logic [3:0] rr;
    logic [3:0] cc;
    rr = r[3:0];
    cc = c[3:0];
    return {rr, cc, 4'h5};
  endfunction

  // Window for accept (r,c): centre (r-1,c-1), lanes MSB first.
  function automatic logic [107:0] exp_win(input int r, input int c);
    return {pix(r-1, c-1), pix(r-1, c-2), pix(r-1, c), pix(r-2, c-1), pix(r, c-1),
            pix(r-2, c-2), pix(r-2, c), pix(r, c-2), pix(r, c)};
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (window_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL gap_quiet: window_valid=%0b frame_err=%0b required 0/0", window_valid, frame_err);
    end
  endtask

  // Streams linear pixel indices 0..n-1 of a frame and checks every accept.
  task automatic run_frame(input bit exp_err_first, input bit gaps, input int n, input bit sof_first);
    int r;
    int c;
    logic exp_vld;
    logic exp_err;
    nwin = 0;
    for (int i = 0; i < n; i++) begin
      r = i / W;
      c = i % W;
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) idle_cycle();
      end
      @(negedge clk);
      pix_valid = 1'b1;
      pix_in    = pix(r, c);
      sof       = (i == 0) && sof_first;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      sof       = 1'b0;
      exp_vld = (r >= 2) && (c >= 2);
      exp_err = (i == 0) && exp_err_first;
      checks++;
      if (window_valid !== exp_vld) begin
        failures++;
        $display("FAIL valid_r%0d_c%0d: got %0b required %0b", r, c, window_valid, exp_vld);
      end
      checks++;
      if (frame_err !== exp_err) begin
        failures++;
        $display("FAIL frame_err_r%0d_c%0d: got %0b required %0b", r, c, frame_err, exp_err);
      end
      if (window_valid === 1'b1) begin
        nwin++;
        checks++;
        if (window_out !== exp_win(r, c)) begin
          failures++;
          $display("FAIL window_r%0d_c%0d: got %027h required %027h", r, c, window_out, exp_win(r, c));
        end
`ifdef SOBEL_WINDOW_COORD_EN
        checks++;
        if (win_x !== 3'(c - 1) || win_y !== 3'(r - 1)) begin
          failures++;
          $display("FAIL coord_r%0d_c%0d: got x=%0d y=%0d required x=%0d y=%0d", r, c, win_x, win_y, c-1, r-1);
        end
`endif
      end
      if (r == 2 && c == 2) begin
        checks++;
        if (window_out[107:96] !== 12'h115 || window_out[47:36] !== 12'h005 ||
            window_out[71:60] !== 12'h015 || window_out[83:72] !== 12'h125 ||
            window_out[11:0] !== 12'h225) begin
          failures++;
          $display("FAIL first_window_lanes: got c=%03h ul=%03h u=%03h r=%03h dr=%03h required 115/005/015/125/225",
                   window_out[107:96], window_out[47:36], window_out[71:60], window_out[83:72], window_out[11:0]);
        end
      end
      if (r == H-1 && c == W-1) begin
        checks++;
        if (window_out[107:96] !== 12'h465 || window_out[11:0] !== 12'h575) begin
          failures++;
          $display("FAIL last_window_lanes: got c=%03h dr=%03h required 465/575",
                   window_out[107:96], window_out[11:0]);
        end
      end
    end
    if (n == W*H) begin
      checks++;
      if (nwin != (W-2)*(H-2)) begin
        failures++;
        $display("FAIL window_count: got %0d required %0d", nwin, (W-2)*(H-2));
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (window_out !== '0 || window_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got win=%027h vld=%0b err=%0b required all 0", window_out, window_valid, frame_err);
    end
`ifdef SOBEL_WINDOW_COORD_EN
    checks++;
    if (win_x !== 3'd0 || win_y !== 3'd0) begin
      failures++;
      $display("FAIL reset_coord: got x=%0d y=%0d required 0/0", win_x, win_y);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full_frame();
    run_frame(1'b0, 1'b0, W*H, 1'b1);
  endtask

  task automatic test_gapped_frame();
    run_frame(1'b0, 1'b1, W*H, 1'b1);
    idle_cycle();
  endtask

  task automatic test_early_sof();
    run_frame(1'b0, 1'b0, 20, 1'b1);
    run_frame(1'b1, 1'b0, W*H, 1'b1);
    idle_cycle();
  endtask

  task automatic test_reset_mid_frame();
    run_frame(1'b0, 1'b0, 3*W + 4, 1'b1);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in    = pix(3, 4);
    reset     = 1'b1;
    #1;
    checks++;
    if (window_out !== '0 || window_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset_outputs: got win=%027h vld=%0b err=%0b required all 0",
               window_out, window_valid, frame_err);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_frame(1'b0, 1'b0, W*H, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_frame();
    test_gapped_frame();
    test_early_sof();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
